// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit between execute and write-back.
// Single-outstanding req/ack data bus with lane steering and timeout.
module ysyx_23060111_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [31:0] in_alu,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_waddr,
   output logic [31:0] out_wdata,
   output logic        out_wen,
   output logic        out_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [4:0]  r_rd;
   logic        r_ld;

   logic        w_acc;
   logic        w_is_mem;
   logic        w_f3_ok;
   logic        w_align_ok;
   logic        w_err;
   logic        w_go_busy;
   logic        w_last;
   logic [31:0] w_st_data;
   logic [3:0]  w_st_strb;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_data;

   assign w_acc     = in_valid && (r_state == IDLE);
   assign w_is_mem  = in_is_load || in_is_store;
   assign w_last    = (r_cnt == LP_LAST);
   assign w_go_busy = w_is_mem && !w_err;

   // Legality: width code, alignment and the load+store conflict
   always_comb begin
      w_f3_ok = 1'b0;
      if (in_is_load) begin
         unique case (in_funct3)
            3'b000, 3'b001, 3'b010,
            3'b100, 3'b101: w_f3_ok = 1'b1;
            default:        w_f3_ok = 1'b0;
         endcase
      end else if (in_is_store) begin
         w_f3_ok = (in_funct3[2] == 1'b0) && (in_funct3[1:0] != 2'b11);
      end
      w_align_ok = 1'b1;
      if (in_funct3[1:0] == 2'b01)
         w_align_ok = (in_addr[0] == 1'b0);
      else if (in_funct3[1:0] == 2'b10)
         w_align_ok = (in_addr[1:0] == 2'b00);
      w_err = w_is_mem &&
              ((in_is_load && in_is_store) || !w_f3_ok || !w_align_ok);
   end

   always_comb begin
      w_st_data = in_wdata;
      w_st_strb = 4'b1111;
      unique case (in_funct3[1:0])
         2'b00: begin
            w_st_data = {4{in_wdata[7:0]}};
            w_st_strb = 4'b0001 << in_addr[1:0];
         end
         2'b01: begin
            w_st_data = {2{in_wdata[15:0]}};
            w_st_strb = 4'b0011 << in_addr[1:0];
         end
         default: begin
            w_st_data = in_wdata;
            w_st_strb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      w_byte = mem_rdata[7:0];
      unique case (r_off)
         2'b00:   w_byte = mem_rdata[7:0];
         2'b01:   w_byte = mem_rdata[15:8];
         2'b10:   w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      unique case (r_f3)
         3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_ld_data = {24'd0, w_byte};
         3'b101:  w_ld_data = {16'd0, w_half};
         default: w_ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_acc) w_next = w_go_busy ? BUSY : DONE;
         BUSY: if (mem_ack || w_last) w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_f3      <= '0;
         r_off     <= '0;
         r_rd      <= '0;
         r_ld      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         out_waddr <= '0;
         out_wdata <= '0;
         out_wen   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (w_acc) begin
               r_cnt <= '0;
               r_f3  <= in_funct3;
               r_off <= in_addr[1:0];
               r_rd  <= in_rd;
               r_ld  <= in_is_load;
               if (w_go_busy) begin
                  mem_req   <= 1'b1;
                  mem_we    <= in_is_store;
                  mem_addr  <= {in_addr[31:2], 2'b00};
                  mem_wdata <= in_is_store ? w_st_data : 32'd0;
                  mem_wstrb <= in_is_store ? w_st_strb : 4'b0000;
               end else begin
                  out_waddr <= in_rd;
                  out_err   <= w_err;
                  out_wen   <= w_err ? 1'b0 : in_wen;
                  out_wdata <= w_err ? 32'd0 : in_alu;
               end
            end
            BUSY: begin
               out_waddr <= r_rd;
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  out_err   <= 1'b0;
                  out_wen   <= r_ld && (r_rd != 5'd0);
                  out_wdata <= r_ld ? w_ld_data : 32'd0;
               end else if (w_last) begin
                  mem_req   <= 1'b0;
                  out_err   <= 1'b1;
                  out_wen   <= 1'b0;
                  out_wdata <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Directed self-checking bench for ysyx_23060111_lsu.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_ysyx_23060111_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_load;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [31:0] in_alu;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_waddr;
   logic [31:0] out_wdata;
   logic        out_wen;
   logic        out_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ysyx_23060111_lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_alu(in_alu),
      .in_rd(in_rd), .in_wen(in_wen),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_waddr(out_waddr), .out_wdata(out_wdata),
      .out_wen(out_wen), .out_err(out_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one op for a single cycle; returns at the negedge after accept
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] alu, input logic [4:0] rd,
                        input logic wen);
      in_valid    = 1'b1;
      in_is_load  = ld;
      in_is_store = st;
      in_funct3   = f3;
      in_addr     = addr;
      in_wdata    = wd;
      in_alu      = alu;
      in_rd       = rd;
      in_wen      = wen;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_idle", {31'd0, in_ready}, 32'd1);
   endtask

   // Load with `waits` ack-less BUSY cycles, then ack with rdata
   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rd_word,
                          input logic [4:0] rd, input int waits,
                          input logic [31:0] exp, input logic exp_wen);
      issue(1'b1, 1'b0, f3, addr, 32'd0, 32'd0, rd, 1'b0);
      check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
      check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tag, "_strb"}, {28'd0, mem_wstrb}, 32'd0);
      for (int i = 0; i < waits; i++) @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = rd_word;
      @(negedge clk);
      mem_ack = 1'b0;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, out_wdata, exp);
      check({tag, "_wen"}, {31'd0, out_wen}, {31'd0, exp_wen});
      check({tag, "_err"}, {31'd0, out_err}, 32'd0);
      check({tag, "_reqoff"}, {31'd0, mem_req}, 32'd0);
      drain();
   endtask

   // Op expected to fail its check: DONE one cycle later, no bus access
   task automatic bad_op(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] addr);
      issue(ld, st, f3, addr, 32'h1111_2222, 32'h3333_4444, 5'd9, 1'b1);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_err"}, {31'd0, out_err}, 32'd1);
      check({tag, "_wen"}, {31'd0, out_wen}, 32'd0);
      check({tag, "_data"}, out_wdata, 32'd0);
      drain();
   endtask

   initial begin
      int req_cycles;
      logic seen;
      rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
      in_funct3 = '0; in_addr = '0; in_wdata = '0; in_alu = '0;
      in_rd = '0; in_wen = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      out_ready = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_wdata", out_wdata, 32'd0);
      check("rst_strb", {28'd0, mem_wstrb}, 32'd0);
      check("rst_maddr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Pass-through
      issue(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h1234_5678, 5'd5, 1'b1);
      check("pt_valid", {31'd0, out_valid}, 32'd1);
      check("pt_data", out_wdata, 32'h1234_5678);
      check("pt_waddr", {27'd0, out_waddr}, 32'd5);
      check("pt_wen", {31'd0, out_wen}, 32'd1);
      check("pt_err", {31'd0, out_err}, 32'd0);
      check("pt_req", {31'd0, mem_req}, 32'd0);
      check("pt_inrdy", {31'd0, in_ready}, 32'd0);
      drain();

      // Loads; 3 waits puts the ack on the final counted cycle
      do_load("lb", 3'b000, 32'h8000_0003, 32'h80FF_0000, 5'd7, 3,
              32'hFFFF_FF80, 1'b1);
      do_load("lbu", 3'b100, 32'h8000_0003, 32'h80FF_0000, 5'd7, 3,
              32'h0000_0080, 1'b1);
      do_load("lh", 3'b001, 32'h8000_0002, 32'h7FFF_1234, 5'd3, 0,
              32'h0000_7FFF, 1'b1);
      do_load("lhn", 3'b001, 32'h8000_0000, 32'h0000_8001, 5'd3, 1,
              32'hFFFF_8001, 1'b1);
      do_load("lhu", 3'b101, 32'h8000_0000, 32'h0000_8001, 5'd3, 1,
              32'h0000_8001, 1'b1);
      do_load("lw", 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 5'd31, 2,
              32'hCAFE_F00D, 1'b1);
      do_load("lbx0", 3'b000, 32'h8000_0001, 32'h0000_5A00, 5'd0, 0,
              32'h0000_005A, 1'b0);

      // SH with zero-wait slave
      issue(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'hDEAD_BEEF, 32'd0,
            5'd4, 1'b1);
      check("sh_req", {31'd0, mem_req}, 32'd1);
      check("sh_we", {31'd0, mem_we}, 32'd1);
      check("sh_addr", mem_addr, 32'h8000_0100);
      check("sh_strb", {28'd0, mem_wstrb}, 32'hC);
      check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("sh_valid", {31'd0, out_valid}, 32'd1);
      check("sh_wen", {31'd0, out_wen}, 32'd0);
      check("sh_err", {31'd0, out_err}, 32'd0);
      check("sh_data", out_wdata, 32'd0);
      drain();

      // SB lane 1
      issue(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h1234_56A5, 32'd0,
            5'd4, 1'b1);
      check("sb_strb", {28'd0, mem_wstrb}, 32'h2);
      check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      drain();

      // Check failures
      bad_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h8000_0001);
      bad_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h8000_0003);
      bad_op("ld_st", 1'b1, 1'b1, 3'b010, 32'h8000_0000);
      bad_op("st_f3", 1'b0, 1'b1, 3'b100, 32'h8000_0000);
      bad_op("ld_f3", 1'b1, 1'b0, 3'b011, 32'h8000_0000);

      // Timeout: no ack ever
      issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'd0, 5'd6, 1'b0);
      req_cycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (mem_req) req_cycles++;
         if (out_valid) seen = 1'b1;
         else @(negedge clk);
      end
      check("to_done", {31'd0, seen}, 32'd1);
      check("to_req_cycles", req_cycles, 32'd4);
      check("to_err", {31'd0, out_err}, 32'd1);
      check("to_wen", {31'd0, out_wen}, 32'd0);
      drain();

      // SW acked on 4th BUSY cycle: ack beats timeout
      issue(1'b0, 1'b1, 3'b010, 32'h8000_0030, 32'h0BAD_CAFE, 32'd0,
            5'd6, 1'b0);
      check("sw_strb", {28'd0, mem_wstrb}, 32'hF);
      check("sw_wdata", mem_wdata, 32'h0BAD_CAFE);
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("sw_req4", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("sw_valid", {31'd0, out_valid}, 32'd1);
      check("sw_err", {31'd0, out_err}, 32'd0);
      drain();

      // Backpressure: outputs hold, new inputs refused
      issue(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h0000_ABCD, 5'd12, 1'b1);
      in_valid = 1'b1;
      in_alu   = 32'h5555_5555;
      in_rd    = 5'd1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_inrdy", {31'd0, in_ready}, 32'd0);
         check("bp_data", out_wdata, 32'h0000_ABCD);
         check("bp_waddr", {27'd0, out_waddr}, 32'd12);
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain();
      check("bp_gone", {31'd0, out_valid}, 32'd0);

      // Reset mid-BUSY
      issue(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'd0, 32'd0, 5'd2, 1'b0);
      check("rb_req", {31'd0, mem_req}, 32'd1);
      #1 rst_n = 1'b0;
      #1 check("rb_req_drop", {31'd0, mem_req}, 32'd0);
      check("rb_inrdy", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("rb_idle", {31'd0, in_ready}, 32'd1);
      check("rb_valid", {31'd0, out_valid}, 32'd0);
      check("rb_req_off", {31'd0, mem_req}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
